// File: rtl/ro_puf_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ro_puf_engine : ring-oscillator PUF engine, one response bit per RO pair
// Revision 1.0
// ----------------------------------------------------------------------------
module ro_puf_engine #(
  parameter int NUM_RO    = 16,
  parameter int SEL_W     = $clog2(NUM_RO),
  parameter int RESP_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*SEL_W-1:0]   challenge,
  input  logic [WIN_W-1:0]     win_len,
  input  logic [NUM_RO-1:0]    ro_in,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] response,
  output logic [RESP_BITS-1:0] tie_mask,
  output logic                 sat
);

  localparam int K_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [K_W-1:0] LAST_K = K_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_RO-1:0]      sync1_q, sync2_q, prev_q;
  logic [NUM_RO-1:0]      rise;
  logic [SEL_W-1:0]       base_a_q, base_a_d, base_b_q, base_b_d;
  logic [SEL_W-1:0]       sel_a, sel_b_raw, sel_b;
  logic [WIN_W-1:0]       win_q, win_d, win_cnt_q, win_cnt_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [CNT_W-1:0]       cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [RESP_BITS-1:0]   resp_q, resp_d, tie_q, tie_d;
  logic                   sat_q, sat_d;
  logic                   ro_en_q, ro_en_d;

  // Oscillator inputs are asynchronous to clk; two flops plus an edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  // Pair for bit k walks both bases together; a colliding B slides to A+1.
  assign sel_a     = base_a_q + SEL_W'(k_q);
  assign sel_b_raw = base_b_q + SEL_W'(k_q);
  assign sel_b     = (sel_b_raw == sel_a) ? sel_a + SEL_W'(1) : sel_b_raw;

  always_comb begin
    state_d   = state_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    win_d     = win_q;
    win_cnt_d = win_cnt_q;
    k_d       = k_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    resp_d    = resp_q;
    tie_d     = tie_q;
    sat_d     = sat_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_CLEAR;
          base_a_d = challenge[SEL_W-1:0];
          base_b_d = challenge[2*SEL_W-1:SEL_W];
          win_d    = (win_len == '0) ? WIN_W'(1) : win_len;
          k_d      = '0;
          sat_d    = 1'b0;
          resp_d   = '0;
          tie_d    = '0;
        end
      end
      S_CLEAR: begin
        cnt_a_d   = '0;
        cnt_b_d   = '0;
        win_cnt_d = win_q;
        state_d   = S_MEASURE;
      end
      S_MEASURE: begin
        if (rise[sel_a]) begin
          if (&cnt_a_q) sat_d = 1'b1;
          else          cnt_a_d = cnt_a_q + 1'b1;
        end
        if (rise[sel_b]) begin
          if (&cnt_b_q) sat_d = 1'b1;
          else          cnt_b_d = cnt_b_q + 1'b1;
        end
        if (win_cnt_q == WIN_W'(1)) state_d = S_COMPARE;
        else                        win_cnt_d = win_cnt_q - 1'b1;
      end
      S_COMPARE: begin
        resp_d[k_q] = (cnt_a_q > cnt_b_q);
        tie_d[k_q]  = (cnt_a_q == cnt_b_q);
        if (k_q == LAST_K) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ro_en_d = (state_d == S_CLEAR) || (state_d == S_MEASURE) || (state_d == S_COMPARE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_a_q  <= '0;
      base_b_q  <= '0;
      win_q     <= '0;
      win_cnt_q <= '0;
      k_q       <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      resp_q    <= '0;
      tie_q     <= '0;
      sat_q     <= 1'b0;
      ro_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      win_q     <= win_d;
      win_cnt_q <= win_cnt_d;
      k_q       <= k_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      resp_q    <= resp_d;
      tie_q     <= tie_d;
      sat_q     <= sat_d;
      ro_en_q   <= ro_en_d;
    end
  end

  assign busy       = (state_q == S_CLEAR) || (state_q == S_MEASURE) || (state_q == S_COMPARE);
  assign resp_valid = (state_q == S_DONE);
  assign ro_en      = ro_en_q;
  assign response   = resp_q;
  assign tie_mask   = tie_q;
  assign sat        = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ro_puf_engine : table-driven and randomized checks against a count model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_ro_puf_engine;

  localparam int NRO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] ro_in;

  logic        start1, ro_en1, busy1, rv1, sat1;
  logic [7:0]  chal1, resp1, tie1;
  logic [15:0] win1;

  logic        start2, ro_en2, busy2, rv2, sat2;
  logic [7:0]  chal2;
  logic [1:0]  resp2, tie2;
  logic [15:0] win2;

  ro_puf_engine dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .challenge(chal1), .win_len(win1),
    .ro_in(ro_in), .ro_en(ro_en1), .busy(busy1), .resp_valid(rv1),
    .response(resp1), .tie_mask(tie1), .sat(sat1)
  );

  ro_puf_engine #(.CNT_W(8), .RESP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .challenge(chal2), .win_len(win2),
    .ro_in(ro_in), .ro_en(ro_en2), .busy(busy2), .resp_valid(rv2),
    .response(resp2), .tie_mask(tie2), .sat(sat2)
  );

  // Every value the DUTs sample, indexed by the clock edge that sampled it.
  logic [15:0] hist [0:65535];
  int ecnt = 0;
  always @(posedge clk) begin
    hist[ecnt] <= ro_in;
    ecnt       <= ecnt + 1;
  end

  int          mode = 0;
  int          half [16];
  int          hold [16];
  logic [15:0] rv;
  int          tk = 0;

  initial begin
    rv    = '0;
    ro_in = '0;
    for (int i = 0; i < 16; i++) hold[i] = 0;
    forever begin
      @(negedge clk);
      tk++;
      for (int i = 0; i < 16; i++) begin
        if (mode == 0) begin
          rv[i] = ((tk / half[i]) % 2) != 0;
        end else if (hold[i] == 0) begin
          rv[i]   = ~rv[i];
          hold[i] = $urandom_range(4, 1);
        end else begin
          hold[i]--;
        end
      end
      ro_in = rv;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count synchronized rising edges of each selected oscillator over each window.
  function automatic void model(input int t, input int a0, input int b0, input int w,
                                input int cmax, input int nb,
                                output logic [7:0] er, output logic [7:0] et, output logic es);
    er = '0; et = '0; es = 1'b0;
    for (int k = 0; k < nb; k++) begin
      int a, b, s, ca, cb;
      a = (a0 + k) % NRO;
      b = (b0 + k) % NRO;
      if (a == b) b = (a + 1) % NRO;
      s = t + k * (w + 2);
      ca = 0; cb = 0;
      for (int e = s + 2; e <= s + 1 + w; e++) begin
        if (hist[e-2][a] && !hist[e-3][a]) begin
          if (ca == cmax) es = 1'b1; else ca++;
        end
        if (hist[e-2][b] && !hist[e-3][b]) begin
          if (cb == cmax) es = 1'b1; else cb++;
        end
      end
      er[k] = (ca > cb);
      et[k] = (ca == cb);
    end
  endfunction

  function automatic logic rv_of(input bit d2);   return d2 ? rv2 : rv1;       endfunction
  function automatic logic busy_of(input bit d2); return d2 ? busy2 : busy1;   endfunction
  function automatic logic roen_of(input bit d2); return d2 ? ro_en2 : ro_en1; endfunction
  function automatic logic [7:0] resp_of(input bit d2); return d2 ? {6'b0, resp2} : resp1; endfunction
  function automatic logic [7:0] tie_of(input bit d2);  return d2 ? {6'b0, tie2} : tie1;   endfunction
  function automatic logic sat_of(input bit d2);  return d2 ? sat2 : sat1;     endfunction

  task automatic set_periodic(input int he, input int ho);
    mode = 0;
    for (int i = 0; i < 16; i++) half[i] = (i % 2 == 0) ? he : ho;
    repeat (6) @(posedge clk);
  endtask

  task automatic launch(input bit d2, input int a, input int b, input int w, output int t);
    @(negedge clk);
    if (d2) begin
      chal2 = {4'(b), 4'(a)}; win2 = 16'(w); start2 = 1'b1;
    end else begin
      chal1 = {4'(b), 4'(a)}; win1 = 16'(w); start1 = 1'b1;
    end
    @(posedge clk); #1;
    t = ecnt - 1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic finish_run(input bit d2, input int a, input int b, input int w,
                            input int t, input string tag);
    int weff, nb, n, bad;
    logic [7:0] er, et;
    logic es;
    weff = (w == 0) ? 1 : w;
    nb   = d2 ? 2 : 8;
    n = 0; bad = 0;
    while (!rv_of(d2) && n < 20000) begin
      if (!busy_of(d2) || !roen_of(d2)) bad++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, ecnt - 1, t + nb * (weff + 2));
    chk({tag, " busy"}, bad, 0);
    chk({tag, " idle"}, {busy_of(d2), roen_of(d2)}, 0);
    model(t, a, b, weff, d2 ? 255 : 65535, nb, er, et, es);
    chk({tag, " response"}, resp_of(d2), er);
    chk({tag, " tie_mask"}, tie_of(d2), et);
    chk({tag, " sat"}, sat_of(d2), es);
  endtask

  typedef struct {
    int          he;
    int          ho;
    int          a;
    int          b;
    int          w;
    bit          fixed;
    logic [7:0]  er;
    logic [7:0]  et;
    logic        es;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, a, b, w;
    for (int i = 0; i < 16; i++) half[i] = 2;
    rst_n = 1'b0;
    start1 = 1'b0; chal1 = '0; win1 = '0;
    start2 = 1'b0; chal2 = '0; win2 = '0;

    vecs[0] = '{2, 4, 0, 1, 100, 1'b1, 8'h55, 8'h00, 1'b0};
    vecs[1] = '{2, 4, 3, 3, 100, 1'b1, 8'hAA, 8'h00, 1'b0};
    vecs[2] = '{2, 2, 0, 1, 64,  1'b1, 8'h00, 8'hFF, 1'b0};
    vecs[3] = '{2, 4, 0, 1, 0,   1'b0, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{2, 4, 5, 12, 37, 1'b0, 8'h00, 8'h00, 1'b0};

    repeat (3) @(posedge clk); #1;
    chk("reset busy",  {busy1, busy2}, 0);
    chk("reset ro_en", {ro_en1, ro_en2}, 0);
    chk("reset valid", {rv1, rv2}, 0);
    chk("reset response", resp1, 0);
    chk("reset tie_mask", tie1, 0);
    chk("reset sat", {sat1, sat2}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      set_periodic(vecs[i].he, vecs[i].ho);
      launch(1'b0, vecs[i].a, vecs[i].b, vecs[i].w, t);
      finish_run(1'b0, vecs[i].a, vecs[i].b, vecs[i].w, t, $sformatf("vec%0d", i));
      if (vecs[i].fixed) begin
        chk($sformatf("vec%0d fixed response", i), resp1, vecs[i].er);
        chk($sformatf("vec%0d fixed tie_mask", i), tie1, vecs[i].et);
        chk($sformatf("vec%0d fixed sat", i), sat1, vecs[i].es);
      end
    end

    mode = 1;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(15, 0);
      b = ($urandom_range(2, 0) == 0) ? a : $urandom_range(15, 0);
      w = $urandom_range(40, 0);
      launch(1'b0, a, b, w, t);
      finish_run(1'b0, a, b, w, t, $sformatf("rand%0d", i));
    end

    // start pulsed mid-window with a different challenge must be ignored
    launch(1'b0, 2, 9, 20, t);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chal1 = 8'h00; win1 = 16'd5; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    finish_run(1'b0, 2, 9, 20, t, "midstart");

    // restart straight out of DONE
    launch(1'b0, 6, 1, 10, t);
    chk("restart valid drop", rv1, 0);
    chk("restart busy", busy1, 1);
    chk("restart response cleared", resp1, 0);
    finish_run(1'b0, 6, 1, 10, t, "restart");

    set_periodic(2, 3);
    launch(1'b1, 0, 1, 1100, t);
    finish_run(1'b1, 0, 1, 1100, t, "sat one");
    chk("sat one fixed response", resp2, 2'b01);
    chk("sat one fixed tie", tie2, 2'b00);
    chk("sat one fixed sat", sat2, 1'b1);
    launch(1'b1, 0, 1, 2000, t);
    finish_run(1'b1, 0, 1, 2000, t, "sat both");
    chk("sat both fixed response", resp2, 2'b00);
    chk("sat both fixed tie", tie2, 2'b11);
    chk("sat both fixed sat", sat2, 1'b1);

    // asynchronous reset in the middle of a later bit's window
    set_periodic(2, 4);
    launch(1'b0, 0, 1, 100, t);
    repeat (3 * 102 + 30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun rst busy", {busy1, busy2}, 0);
    chk("midrun rst ro_en", {ro_en1, ro_en2}, 0);
    chk("midrun rst valid", {rv1, rv2}, 0);
    chk("midrun rst response", {resp1, resp2}, 0);
    chk("midrun rst tie_mask", {tie1, tie2}, 0);
    chk("midrun rst sat", {sat1, sat2}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("post rst idle", {busy1, rv1, ro_en1}, 0);
    launch(1'b0, 7, 2, 15, t);
    finish_run(1'b0, 7, 2, 15, t, "post rst run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
